// File: rtl/servo_pwm_gen_pkg.sv
// Shared servo constants and the width clamp used by the PWM generator and the tracker controller.
package servo_pkg;

    localparam int PERIOD_TICKS = 2000;
    localparam int MIN_PW       = 100;
    localparam int MAX_PW       = 200;
    localparam int STEP         = 4;

    function automatic int clamp(input int value, input int lo, input int hi);
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/servo_pwm_gen_if.sv
// Command channel of the servo PWM generator.
// valid/ready: the master holds cmd_valid and cmd_pw stable until the cycle where
// cmd_valid & cmd_ready are both high; that rising clk edge is the single transfer.
interface servo_pwm_gen_if #(
    parameter int PW_W = $clog2(servo_pkg::PERIOD_TICKS)
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [PW_W-1:0] cmd_pw;

    modport master (output cmd_valid, output cmd_pw, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_pw, output cmd_ready);
endinterface

// File: rtl/servo_pwm_gen_tick_edge_detect.sv
// Turns a slow level (divided clock) into a one-clk pulse on each rising edge.
module tick_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic tick_o
);
    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign tick_o = level_i & ~level_q;
endmodule

// File: rtl/servo_pwm_gen.sv
// Servo pulse generator: one pulse per frame, width clamped from a command and slew-limited per frame.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int PERIOD_TICKS = servo_pkg::PERIOD_TICKS,
    parameter int MIN_PW       = servo_pkg::MIN_PW,
    parameter int MAX_PW       = servo_pkg::MAX_PW,
    parameter int STEP         = servo_pkg::STEP,
    parameter int PW_W         = $clog2(PERIOD_TICKS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sclk_in,
    servo_pwm_gen_if.slave  cmd,
    output logic            pwm,
    output logic            frame_start,
    output logic            at_target
);
    localparam logic [PW_W-1:0] LAST_CNT = PW_W'(PERIOD_TICKS - 1);
    localparam logic [PW_W-1:0] MID_PW   = PW_W'((MIN_PW + MAX_PW) / 2);
    localparam logic [PW_W-1:0] STEP_W   = PW_W'(STEP);

    logic            tick;
    logic            wrap;
    logic            accept;
    logic [PW_W-1:0] cmd_pw_clamped;

    logic [PW_W-1:0] cnt_q,     cnt_d;
    logic            pending_q, pending_d;
    logic [PW_W-1:0] pend_pw_q, pend_pw_d;
    logic [PW_W-1:0] target_q,  target_d;
    logic [PW_W-1:0] cur_pw_q,  cur_pw_d;
    logic            pwm_q;
    logic            frame_start_q;

    tick_edge_detect u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (sclk_in),
        .tick_o  (tick)
    );

    assign wrap           = tick && (cnt_q == LAST_CNT);
    assign accept         = cmd.cmd_valid && !pending_q;
    assign cmd_pw_clamped = PW_W'(clamp(int'(cmd.cmd_pw), MIN_PW, MAX_PW));

    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        pend_pw_d = pend_pw_q;
        target_d  = target_q;
        cur_pw_d  = cur_pw_q;

        if (tick) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end

        // Slew uses the old target; a freshly loaded target acts one frame later.
        if (wrap) begin
            if (target_q > cur_pw_q) begin
                cur_pw_d = (target_q - cur_pw_q <= STEP_W) ? target_q : cur_pw_q + STEP_W;
            end else if (cur_pw_q > target_q) begin
                cur_pw_d = (cur_pw_q - target_q <= STEP_W) ? target_q : cur_pw_q - STEP_W;
            end
            if (pending_q) begin
                target_d  = pend_pw_q;
                pending_d = 1'b0;
            end
        end

        // accept needs pending_q low, so it never collides with the clear above.
        if (accept) begin
            pending_d = 1'b1;
            pend_pw_d = cmd_pw_clamped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            pend_pw_q     <= MID_PW;
            target_q      <= MID_PW;
            cur_pw_q      <= MID_PW;
            pwm_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            pend_pw_q     <= pend_pw_d;
            target_q      <= target_d;
            cur_pw_q      <= cur_pw_d;
            pwm_q         <= (cnt_q < cur_pw_q);
            frame_start_q <= wrap;
        end
    end

    assign cmd.cmd_ready = ~pending_q;
    assign pwm           = pwm_q;
    assign frame_start   = frame_start_q;
    assign at_target     = (cur_pw_q == target_q) && !pending_q;
endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen: frame widths go through a queue checked by a frame monitor.
module tb_servo_pwm_gen;
  localparam int PERIOD_TICKS = 256;
  localparam int MIN_PW = 100;
  localparam int MAX_PW = 200;
  localparam int STEP = 4;
  localparam int PW_W = $clog2(PERIOD_TICKS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk_in = 1'b0;
  logic pwm;
  logic frame_start;
  logic at_target;

  int checks = 0;
  int errors = 0;
  logic [PW_W-1:0] exp_q[$];

  servo_pwm_gen_if #(.PW_W(PW_W)) cmd_if ();

  servo_pwm_gen #(
    .PERIOD_TICKS(PERIOD_TICKS),
    .MIN_PW(MIN_PW),
    .MAX_PW(MAX_PW),
    .STEP(STEP),
    .PW_W(PW_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sclk_in(sclk_in),
    .cmd(cmd_if),
    .pwm(pwm),
    .frame_start(frame_start),
    .at_target(at_target)
  );

  // clock / reset block: clk period 10, sclk toggles every clk so one tick per 2 clk
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      sclk_in = ~sclk_in;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 2000);
    checks++;
    if (!frame_start) begin
      errors++;
      $display("FAIL %s: no frame_start within 2000 clk", tag);
    end
  endtask

  task automatic send_cmd(input logic [PW_W-1:0] v);
    int n;
    n = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_pw = v;
    while (!cmd_if.cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cmd_if.cmd_ready) begin
      errors++;
      $display("FAIL send_cmd: cmd_ready stuck low for value %0d", v);
    end
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  // scoreboard monitor: counts pwm-high clk per frame, compares with 2*expected width
  initial begin
    int hi_cnt;
    bit measuring;
    logic [PW_W-1:0] e;
    hi_cnt = 0;
    measuring = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hi_cnt = 0;
        measuring = 1'b0;
      end else begin
        if (pwm) hi_cnt++;
        if (frame_start) begin
          if (measuring) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL frame_width: got %0d high clk, no expected width queued", hi_cnt);
            end else begin
              e = exp_q.pop_front();
              check("frame_width", hi_cnt, 2 * int'(e));
            end
          end
          hi_cnt = 0;
          measuring = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [15:0] big;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_pw = '0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pwm", pwm, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_at_target", at_target, 1);
    rst_n = 1'b1;

    // idle frames at the mid width
    wait_fs("f1");
    exp_q.push_back(PW_W'(150));
    check("idle_ready", cmd_if.cmd_ready, 1);
    check("idle_at_target", at_target, 1);
    wait_fs("f2");
    exp_q.push_back(PW_W'(150));

    // 170 mid-frame: next boundary only loads the target, then +4 per frame
    repeat (50) @(negedge clk);
    send_cmd(PW_W'(170));
    check("ready_low_after_xfer", cmd_if.cmd_ready, 0);
    check("at_target_pending", at_target, 0);
    wait_fs("f3");
    exp_q.push_back(PW_W'(150));
    check("ready_back_after_load", cmd_if.cmd_ready, 1);
    check("at_target_slewing", at_target, 0);
    for (int i = 1; i <= 5; i++) begin
      wait_fs("ramp170");
      exp_q.push_back(PW_W'(150 + 4 * i));
    end
    check("at_target_170", at_target, 1);

    // all-ones clamps to MAX_PW
    repeat (50) @(negedge clk);
    big = 16'hFFFF;
    send_cmd(big[PW_W-1:0]);
    wait_fs("load200");
    exp_q.push_back(PW_W'(170));
    for (int i = 1; i <= 7; i++) begin
      wait_fs("ramp200");
      exp_q.push_back(PW_W'(170 + 4 * i));
    end
    wait_fs("reach200");
    exp_q.push_back(PW_W'(200));
    check("at_target_200", at_target, 1);
    wait_fs("hold200");
    exp_q.push_back(PW_W'(200));

    // 120 then a second command (5) held valid while the first is pending
    repeat (50) @(negedge clk);
    send_cmd(PW_W'(120));
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_pw = PW_W'(5);
    check("ready_low_while_pending", cmd_if.cmd_ready, 0);
    wait_fs("load120");
    exp_q.push_back(PW_W'(200));
    check("ready_high_after_boundary", cmd_if.cmd_ready, 1);
    @(negedge clk);
    check("second_cmd_transferred", cmd_if.cmd_ready, 0);
    cmd_if.cmd_valid = 1'b0;
    wait_fs("load100");
    exp_q.push_back(PW_W'(196));
    check("ready_after_second_load", cmd_if.cmd_ready, 1);
    check("at_target_down", at_target, 0);
    for (int i = 1; i <= 24; i++) begin
      wait_fs("ramp100");
      exp_q.push_back(PW_W'(196 - 4 * i));
    end
    wait_fs("hold100");
    exp_q.push_back(PW_W'(100));
    check("at_target_100", at_target, 1);

    // command offered exactly on the boundary edge: 512 clk after this frame_start
    repeat (511) @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_pw = PW_W'(140);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    check("boundary_frame_start", frame_start, 1);
    check("boundary_accepted", cmd_if.cmd_ready, 0);
    exp_q.push_back(PW_W'(100));
    wait_fs("boundary_load");
    exp_q.push_back(PW_W'(100));
    check("boundary_ready_back", cmd_if.cmd_ready, 1);
    wait_fs("boundary_step1");
    exp_q.push_back(PW_W'(104));
    wait_fs("boundary_step2");
    exp_q.push_back(PW_W'(108));

    // reset mid-pulse with a command pending
    repeat (20) @(negedge clk);
    send_cmd(PW_W'(180));
    check("pre_reset_pwm", pwm, 1);
    check("pre_reset_pending", cmd_if.cmd_ready, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm", pwm, 0);
    check("async_rst_ready", cmd_if.cmd_ready, 1);
    check("async_rst_at_target", at_target, 1);
    check("async_rst_frame_start", frame_start, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_fs("post_reset");
      exp_q.push_back(PW_W'(150));
    end
    wait_fs("post_reset_last");
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
